// File: rtl/axi_stream_insert_header.sv
// rtl/axi_stream_insert_header.sv - prepend a 1..B byte header to each AXI-Stream packet and repack into full beats
// Optional output skid buffer (registered ready_in/ready_insert) under macro AXIS_HDR_SKID_EN.
module axi_stream_insert_header #(
  parameter int DATA_WD = 32
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           valid_in,
  input  logic [DATA_WD-1:0]             data_in,
  input  logic [DATA_WD/8-1:0]           keep_in,
  input  logic                           last_in,
  output logic                           ready_in,
  output logic                           valid_out,
  output logic [DATA_WD-1:0]             data_out,
  output logic [DATA_WD/8-1:0]           keep_out,
  output logic                           last_out,
  input  logic                           ready_out,
  input  logic                           valid_insert,
  input  logic [DATA_WD-1:0]             data_insert,
  input  logic [DATA_WD/8-1:0]           keep_insert,
  input  logic [$clog2(DATA_WD/8)-1:0]   byte_insert_cnt,
  output logic                           ready_insert
);

  localparam int B    = DATA_WD / 8;
  localparam int CNTW = $clog2(B) + 1;

  typedef enum logic [1:0] {IDLE, STREAM, FLUSH} state_t;

  function automatic logic [B-1:0] top_ones(input int n);
    logic [B-1:0] m;
    m = '0;
    for (int i = 0; i < B; i++) begin
      if (i < n) m[B-1-i] = 1'b1;
    end
    return m;
  endfunction

  function automatic logic [DATA_WD-1:0] byte_mask(input logic [B-1:0] k);
    logic [DATA_WD-1:0] m;
    m = '0;
    for (int i = 0; i < B; i++) m[8*i +: 8] = {8{k[i]}};
    return m;
  endfunction

  function automatic int popcnt(input logic [B-1:0] k);
    int c;
    c = 0;
    for (int i = 0; i < B; i++) c = c + int'(k[i]);
    return c;
  endfunction

  state_t              state;
  logic                run;
  logic [DATA_WD-1:0]  carry;
  logic [CNTW-1:0]     cnt;
  logic                slot_free;

  int                  hi, kk, room, h_ins;
  logic                hs_ins, hs_in, fits;
  logic [DATA_WD-1:0]  hdr_carry, pay_carry;
  logic [CNTW-1:0]     flush_cnt;

  logic                beat_valid;
  logic [DATA_WD-1:0]  beat_data;
  logic [B-1:0]        beat_keep;
  logic                beat_last;

  // run stays low for the cycle after a reset edge so both readies read 0 there
  always_comb begin
    hi           = int'(cnt);
    kk           = popcnt(keep_in);
    room         = B - hi;
    h_ins        = (byte_insert_cnt == '0) ? B : int'(byte_insert_cnt);
    fits         = kk <= room;
    ready_insert = run && (state == IDLE) && slot_free;
    ready_in     = run && (state == STREAM) && slot_free;
    hs_ins       = valid_insert && ready_insert;
    hs_in        = valid_in && ready_in;
    hdr_carry    = (data_insert & byte_mask(keep_insert)) << (8 * (B - h_ins));
    pay_carry    = data_in << (8 * room);
    flush_cnt    = CNTW'(kk - room);

    beat_valid = 1'b0;
    beat_data  = '0;
    beat_keep  = '0;
    beat_last  = 1'b0;
    if (hs_in) begin
      beat_valid = 1'b1;
      if (last_in && fits) begin
        beat_keep = top_ones(hi + kk);
        beat_last = 1'b1;
      end else begin
        beat_keep = '1;
      end
      beat_data = (carry | (data_in >> (8 * hi))) & byte_mask(beat_keep);
    end else if (run && state == FLUSH && slot_free) begin
      beat_valid = 1'b1;
      beat_keep  = top_ones(hi);
      beat_last  = 1'b1;
      beat_data  = carry & byte_mask(beat_keep);
    end
  end

  // carry is always kept top-aligned with zeros below its valid bytes
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      run   <= 1'b0;
      state <= IDLE;
      carry <= '0;
      cnt   <= '0;
    end else begin
      run <= 1'b1;
      case (state)
        IDLE: begin
          if (hs_ins) begin
            carry <= hdr_carry;
            cnt   <= CNTW'(h_ins);
            state <= STREAM;
          end
        end
        STREAM: begin
          if (hs_in) begin
            if (last_in && fits) begin
              carry <= '0;
              cnt   <= '0;
              state <= IDLE;
            end else if (last_in) begin
              carry <= pay_carry & byte_mask(top_ones(kk - room));
              cnt   <= flush_cnt;
              state <= FLUSH;
            end else begin
              carry <= pay_carry;
            end
          end
        end
        FLUSH: begin
          if (slot_free) begin
            carry <= '0;
            cnt   <= '0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef AXIS_HDR_SKID_EN
  logic               sk_valid;
  logic [DATA_WD-1:0] sk_data;
  logic [B-1:0]       sk_keep;
  logic               sk_last;

  // output register plus one spare entry; upstream only stalls on the registered spare-full flag
  assign slot_free = !sk_valid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_out <= 1'b0;
      data_out  <= '0;
      keep_out  <= '0;
      last_out  <= 1'b0;
      sk_valid  <= 1'b0;
      sk_data   <= '0;
      sk_keep   <= '0;
      sk_last   <= 1'b0;
    end else if (beat_valid) begin
      if (!valid_out || ready_out) begin
        valid_out <= 1'b1;
        data_out  <= beat_data;
        keep_out  <= beat_keep;
        last_out  <= beat_last;
      end else begin
        sk_valid <= 1'b1;
        sk_data  <= beat_data;
        sk_keep  <= beat_keep;
        sk_last  <= beat_last;
      end
    end else if (valid_out && ready_out) begin
      valid_out <= sk_valid;
      data_out  <= sk_data;
      keep_out  <= sk_keep;
      last_out  <= sk_last;
      sk_valid  <= 1'b0;
      sk_data   <= '0;
      sk_keep   <= '0;
      sk_last   <= 1'b0;
    end
  end
`else
  assign slot_free = !valid_out || ready_out;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_out <= 1'b0;
      data_out  <= '0;
      keep_out  <= '0;
      last_out  <= 1'b0;
    end else if (beat_valid) begin
      valid_out <= 1'b1;
      data_out  <= beat_data;
      keep_out  <= beat_keep;
      last_out  <= beat_last;
    end else if (ready_out) begin
      valid_out <= 1'b0;
      data_out  <= '0;
      keep_out  <= '0;
      last_out  <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_axi_stream_insert_header.sv
// tb/tb_axi_stream_insert_header.sv - directed self-checking bench for axi_stream_insert_header (DATA_WD=32)
module tb_axi_stream_insert_header;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_in;
  logic [31:0] data_in;
  logic [3:0]  keep_in;
  logic        last_in;
  logic        ready_in;
  logic        valid_out;
  logic [31:0] data_out;
  logic [3:0]  keep_out;
  logic        last_out;
  logic        ready_out;
  logic        valid_insert;
  logic [31:0] data_insert;
  logic [3:0]  keep_insert;
  logic [1:0]  byte_insert_cnt;
  logic        ready_insert;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  axi_stream_insert_header #(.DATA_WD(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .valid_in(valid_in), .data_in(data_in), .keep_in(keep_in), .last_in(last_in), .ready_in(ready_in),
    .valid_out(valid_out), .data_out(data_out), .keep_out(keep_out), .last_out(last_out), .ready_out(ready_out),
    .valid_insert(valid_insert), .data_insert(data_insert), .keep_insert(keep_insert),
    .byte_insert_cnt(byte_insert_cnt), .ready_insert(ready_insert)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_beat(input string tag, input logic [31:0] d, input logic [3:0] k, input logic l);
    check({tag, ".valid"}, 64'(valid_out), 64'(1'b1));
    check({tag, ".data"},  64'(data_out),  64'(d));
    check({tag, ".keep"},  64'(keep_out),  64'(k));
    check({tag, ".last"},  64'(last_out),  64'(l));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; valid_in = 1'b0; data_in = '0; keep_in = '0; last_in = 1'b0;
    ready_out = 1'b1; valid_insert = 1'b0; data_insert = '0; keep_insert = '0; byte_insert_cnt = '0;
    step();
    check("rst.valid_out", 64'(valid_out), 64'(0));
    check("rst.data_out", 64'(data_out), 64'(0));
    check("rst.ready_in", 64'(ready_in), 64'(0));
    check("rst.ready_insert", 64'(ready_insert), 64'(0));
    rst_n = 1'b1;
    step();
    check("post_rst.ready_insert", 64'(ready_insert), 64'(1));

    // T1: H=2, payload arrives together with the header and must wait
    valid_insert = 1'b1; data_insert = 32'hAABBCCDD; keep_insert = 4'b0011; byte_insert_cnt = 2'd2;
    valid_in = 1'b1; data_in = 32'h01020304; keep_in = 4'b1111; last_in = 1'b0;
    #1 check("t1.ready_in_early", 64'(ready_in), 64'(0));
    step();
    valid_insert = 1'b0;
    check("t1.no_beat_yet", 64'(valid_out), 64'(0));
    step();
    check_beat("t1.b0", 32'hCCDD0102, 4'b1111, 1'b0);
    data_in = 32'h05060708; keep_in = 4'b1100; last_in = 1'b1;
    step();
    check_beat("t1.b1", 32'h03040506, 4'b1111, 1'b1);
    valid_in = 1'b0; last_in = 1'b0;

    // T2: H=3, header accepted in the same cycle the previous last beat leaves
    valid_insert = 1'b1; data_insert = 32'h11223344; keep_insert = 4'b0111; byte_insert_cnt = 2'd3;
    #1 check("t2.ready_insert_overlap", 64'(ready_insert), 64'(1));
    step();
    valid_insert = 1'b0;
    check("t2.idle_gap", 64'(valid_out), 64'(0));
    valid_in = 1'b1; data_in = 32'hA0A1A2A3; keep_in = 4'b1110; last_in = 1'b1;
    step();
    check_beat("t2.b0", 32'h223344A0, 4'b1111, 1'b0);
    valid_in = 1'b0; last_in = 1'b0;
    #1 check("t2.flush_ready_in", 64'(ready_in), 64'(0));
    step();
    check_beat("t2.flush", 32'hA1A20000, 4'b1100, 1'b1);

    // T3 + T4: H=4 via cnt 0, then sink stalls 16 cycles
    valid_insert = 1'b1; data_insert = 32'h11223344; keep_insert = 4'b1111; byte_insert_cnt = 2'd0;
    step();
    valid_insert = 1'b0;
    valid_in = 1'b1; data_in = 32'h55667788; keep_in = 4'b1000; last_in = 1'b1;
    ready_out = 1'b0;
    step();
    valid_in = 1'b0; last_in = 1'b0;
    for (int i = 0; i < 16; i++) begin
      check_beat("t4.stall", 32'h11223344, 4'b1111, 1'b0);
      check("t4.ready_in", 64'(ready_in), 64'(0));
      step();
    end
    check("t4.ready_insert_flush", 64'(ready_insert), 64'(0));
    ready_out = 1'b1;
    step();
    check_beat("t3.flush", 32'h55000000, 4'b1000, 1'b1);
    step();
    check("t4.no_dup", 64'(valid_out), 64'(0));

    // T5: payload waits for its header
    valid_in = 1'b1; data_in = 32'hDEADBEEF; keep_in = 4'b1111; last_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("t5.ready_in_wait", 64'(ready_in), 64'(0));
      step();
    end
    valid_insert = 1'b1; data_insert = 32'h000000EE; keep_insert = 4'b0001; byte_insert_cnt = 2'd1;
    step();
    valid_insert = 1'b0;
    check("t5.ready_in_open", 64'(ready_in), 64'(1));
    step();
    valid_in = 1'b0; last_in = 1'b0;
    check_beat("t5.b0", 32'hEEDEADBE, 4'b1111, 1'b0);
    step();
    check_beat("t5.flush", 32'hEF000000, 4'b1000, 1'b1);

    // T6: reset mid-packet discards header and carry
    valid_insert = 1'b1; data_insert = 32'h0000CAFE; keep_insert = 4'b0011; byte_insert_cnt = 2'd2;
    step();
    valid_insert = 1'b0;
    valid_in = 1'b1; data_in = 32'h11112222; keep_in = 4'b1111; last_in = 1'b0;
    step();
    check_beat("t6.pre", 32'hCAFE1111, 4'b1111, 1'b0);
    valid_in = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("t6.valid_out", 64'(valid_out), 64'(0));
    check("t6.data_out", 64'(data_out), 64'(0));
    check("t6.keep_out", 64'(keep_out), 64'(0));
    check("t6.last_out", 64'(last_out), 64'(0));
    check("t6.ready_in", 64'(ready_in), 64'(0));
    check("t6.ready_insert", 64'(ready_insert), 64'(0));
    step();
    check("t6.ready_insert_rel", 64'(ready_insert), 64'(1));
    valid_insert = 1'b1; data_insert = 32'h00001234; keep_insert = 4'b0011; byte_insert_cnt = 2'd2;
    step();
    valid_insert = 1'b0;
    valid_in = 1'b1; data_in = 32'h0A0B0C0D; keep_in = 4'b1111; last_in = 1'b1;
    step();
    valid_in = 1'b0; last_in = 1'b0;
    check_beat("t6.b0", 32'h12340A0B, 4'b1111, 1'b0);
    step();
    check_beat("t6.flush", 32'h0C0D0000, 4'b1100, 1'b1);
    step();
    check("t6.drain", 64'(valid_out), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
